// File: rtl/switch_debouncer.sv
// Four-channel switch debouncer: two-flop synchronizer per bit, then a per-channel
// saturating counter that must see DEBOUNCE_COUNT consecutive differing samples to accept.
module switch_debouncer #(
    parameter int DEBOUNCE_COUNT = 50000,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] raw_in,
    output logic [3:0] switches_out,
    output logic [3:0] rise_pulse,
    output logic [3:0] fall_pulse,
    output logic       any_change
);

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(DEBOUNCE_COUNT - 1);

    logic [3:0]             sync0_q, sync0_d;
    logic [3:0]             sync1_q, sync1_d;
    logic [COUNT_WIDTH-1:0] cnt_q [4];
    logic [COUNT_WIDTH-1:0] cnt_d [4];
    logic [3:0]             state_q, state_d;
    logic [3:0]             rise_q, rise_d;
    logic [3:0]             fall_q, fall_d;
    logic                   any_q, any_d;

    always_comb begin
        sync0_d = raw_in;
        sync1_d = sync0_q;
        state_d = state_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int ch = 0; ch < 4; ch++) begin
            cnt_d[ch] = '0;
            // STABLE vs COUNTING is implied by comparing sync1 against the accepted level.
            if (sync1_q[ch] != state_q[ch]) begin
                if (cnt_q[ch] >= CNT_MAX) begin
                    state_d[ch] = sync1_q[ch];
                    rise_d[ch]  = sync1_q[ch];
                    fall_d[ch]  = ~sync1_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync0_q <= '0;
            sync1_q <= '0;
            state_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                cnt_q[ch] <= '0;
            end
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            for (int ch = 0; ch < 4; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
        end
    end

    assign switches_out = state_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign any_change   = any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_COUNT = 4; inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_switch_debouncer;

    logic       clock;
    logic       reset;
    logic [3:0] raw_in;
    logic [3:0] switches_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;
    logic       any_change;

    int n_checks = 0;
    int n_fail   = 0;

    switch_debouncer #(
        .DEBOUNCE_COUNT(4),
        .COUNT_WIDTH   (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .raw_in      (raw_in),
        .switches_out(switches_out),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .any_change  (any_change)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] sw, input logic [3:0] rp,
                             input logic [3:0] fp, input logic ac);
        check({tag, "_sw"},   16'(switches_out), 16'(sw));
        check({tag, "_rise"}, 16'(rise_pulse),   16'(rp));
        check({tag, "_fall"}, 16'(fall_pulse),   16'(fp));
        check({tag, "_any"},  16'(any_change),   16'(ac));
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = 4'b0000;
        step(2);
        check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        step(3);

        // Clean rise on channel 0: accepted exactly on the 6th edge.
        raw_in = 4'b0001;
        step(5);
        check_all("rise0_e5", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(1);
        check_all("rise0_e6", 4'b0001, 4'b0001, 4'b0000, 1'b1);
        step(1);
        check_all("rise0_e7", 4'b0001, 4'b0000, 4'b0000, 1'b0);

        // Bring channel 1 up, then a 2-cycle low glitch must be rejected.
        raw_in = 4'b0011;
        step(6);
        check_all("rise1", 4'b0011, 4'b0010, 4'b0000, 1'b1);
        step(1);
        raw_in = 4'b0001;
        step(2);
        raw_in = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("glitch_sw",  16'(switches_out), 16'h0003);
            check("glitch_any", 16'(any_change),   16'h0000);
        end
        // A real fall now needs the full count again (counter was cleared).
        raw_in = 4'b0001;
        step(5);
        check_all("fall1_e5", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        step(1);
        check_all("fall1_e6", 4'b0001, 4'b0000, 4'b0010, 1'b1);
        step(1);

        // Return to all-zero, then two channels rise together.
        raw_in = 4'b0000;
        step(6);
        check_all("fall0", 4'b0000, 4'b0000, 4'b0001, 1'b1);
        step(1);
        raw_in = 4'b1010;
        step(5);
        check_all("multi_e5", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step(1);
        check_all("multi_e6", 4'b1010, 4'b1010, 4'b0000, 1'b1);
        step(1);
        check_all("multi_e7", 4'b1010, 4'b0000, 4'b0000, 1'b0);

        // Channel 2 up, then down.
        raw_in = 4'b1110;
        step(6);
        check_all("rise2", 4'b1110, 4'b0100, 4'b0000, 1'b1);
        step(1);
        raw_in = 4'b1010;
        step(5);
        check_all("fall2_e5", 4'b1110, 4'b0000, 4'b0000, 1'b0);
        step(1);
        check_all("fall2_e6", 4'b1010, 4'b0000, 4'b0100, 1'b1);
        step(1);
        check_all("fall2_e7", 4'b1010, 4'b0000, 4'b0000, 1'b0);

        // Reset mid-count (CNT = 2 on channel 0) discards the partial count.
        raw_in = 4'b1011;
        step(4);
        reset = 1'b1;
        step(1);
        check_all("midrst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("postrst_sw",  16'(switches_out), 16'h0000);
            check("postrst_any", 16'(any_change),   16'h0000);
        end
        step(1);
        check_all("postrst_e6", 4'b1011, 4'b1011, 4'b0000, 1'b1);
        step(1);

        // Toggling every cycle never gets accepted.
        reset  = 1'b1;
        raw_in = 4'b0000;
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            raw_in = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            step(1);
            check("toggle_sw",    16'(switches_out),            16'h0000);
            check("toggle_pulse", 16'(rise_pulse | fall_pulse), 16'h0000);
            check("toggle_any",   16'(any_change),              16'h0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter DEBOUNCE_COUNT, default 50000: number of consecutive cycles a synchronized input must differ from the accepted state before it is accepted; legal range 1 .. 2^COUNT_WIDTH.
REQ-002 Parameter COUNT_WIDTH, default 16: width of each per-channel counter.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: raw_in  input  4  asynchronous, bouncing board switch levels, one bit per channel.
REQ-006 Port: switches_out  output  4  registered debounced levels; drives the IO controller's 4-bit switch input.
REQ-007 Port: rise_pulse  output  4  registered one-cycle pulse per channel when its accepted level goes 0->1.
REQ-008 Port: fall_pulse  output  4  registered one-cycle pulse per channel when its accepted level goes 1->0.
REQ-009 Port: any_change  output  1  registered OR of all rise_pulse and fall_pulse bits in the same cycle.

Function
REQ-010 Each of the 4 channels SHALL be independent and identical; no channel's state affects another.
REQ-011 Each channel SHALL pass raw_in through a two-flop synchronizer (sync0 then sync1); only sync1 feeds the debounce logic.
REQ-012 Per channel, accepted state S SHALL be the corresponding switches_out bit; counter CNT is COUNT_WIDTH bits.
REQ-013 States: STABLE (sync1 == S) and COUNTING (sync1 != S); state is implied by comparing sync1 with S, with no separate state register required.
REQ-014 Each edge with sync1 == S SHALL set CNT to 0, hold S, and drive that channel's pulses to 0.
REQ-015 Each edge with sync1 != S and CNT < DEBOUNCE_COUNT-1 SHALL increment CNT by 1 and hold S.
REQ-016 Each edge with sync1 != S and CNT == DEBOUNCE_COUNT-1 SHALL load S <= sync1 and CNT <= 0, and assert rise_pulse (new S = 1) or fall_pulse (new S = 0) for exactly that one following cycle.
REQ-017 CNT SHALL never exceed DEBOUNCE_COUNT-1 and SHALL never wrap.
REQ-018 Latency: a clean level change on raw_in, first sampled at rising edge 1 and held, SHALL appear on switches_out (with its pulse) after rising edge DEBOUNCE_COUNT+2.
REQ-019 Glitch rejection: if sync1 returns to S before acceptance, CNT SHALL clear to 0, and a later change SHALL restart the full count; switches_out SHALL not change and no pulse SHALL fire.
REQ-020 rise_pulse and fall_pulse of one channel SHALL never be asserted in the same cycle; no pulse SHALL last longer than one cycle unless a new acceptance occurs on the next edge.
REQ-021 Multiple channels accepting on the same edge SHALL each pulse in the same cycle; any_change SHALL be 1 for that single cycle.

Reset
REQ-022 While reset is high at a rising edge, sync0, sync1, CNT, switches_out, rise_pulse, fall_pulse and any_change SHALL all be loaded with 0.
REQ-023 Reset asserted mid-count SHALL discard the partial count, and no pulse SHALL be generated on or after that edge.
REQ-024 After reset release with raw_in held at 1, the channel SHALL accept 1 after DEBOUNCE_COUNT+2 edges and SHALL emit rise_pulse, since 1 is a real change from the reset state.

Verification (DEBOUNCE_COUNT = 4)
REQ-025 Reset, then raw_in 4'b0000 -> 4'b0001 held: switches_out = 4'b0001 after edge 6; rise_pulse = 4'b0001 and any_change = 1 for that single cycle; then both return to 0.
REQ-026 Channel 1 starts accepted at 1, then raw_in[1] = 0 for 2 cycles and back to 1: switches_out[1] stays 1; no pulse fires; CNT returns to 0.
REQ-027 raw_in 4'b0000 -> 4'b1010 on one edge and held: switches_out = 4'b1010 after edge 6; rise_pulse = 4'b1010 for one cycle; any_change = 1 for one cycle.
REQ-028 Channel 2 accepted at 1, then raw_in[2] = 0 held: switches_out[2] = 0 after edge 6; fall_pulse = 4'b0100 for one cycle; rise_pulse stays 0.
REQ-029 Reset asserted for one edge when CNT = 2, with raw_in still changed: all outputs read 0 after that edge; no pulse fires; the change is accepted only 6 edges after reset deasserts.
REQ-030 raw_in toggling every cycle for 100 cycles: switches_out and all pulses stay 0 throughout.
